// File: rtl/hazard_pkg.sv
// hazard_pkg: shared result-type codes, hazard descriptor type and Tnew helper
//   D_* localparams : default widths used by the interface, the pipe and the descriptor struct
//   res_e           : result-type codes carried with each instruction
//   hz_desc_t       : one stage's hazard descriptor {valid, ra1, ra2, wa, res, tnew}
//   TNEW_SAT_ZERO   : Tnew after one advance, saturating at zero
package hazard_pkg;
    localparam int D_AW     = 5;
    localparam int D_RW     = 3;
    localparam int D_TW     = 2;
    localparam int D_NSTAGE = 3;
    typedef enum logic [D_RW-1:0] {RES_NONE, RES_ALU, RES_DM, RES_PC, RES_MD, RES_CP0} res_e;
    typedef struct packed {
        logic            valid;
        logic [D_AW-1:0] ra1;
        logic [D_AW-1:0] ra2;
        logic [D_AW-1:0] wa;
        logic [D_RW-1:0] res;
        logic [D_TW-1:0] tnew;
    } hz_desc_t;
    function automatic int unsigned TNEW_SAT_ZERO(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction
endpackage

// File: rtl/hazard_pipe_if.sv
// hazard_pipe_if: decode-side request and hazard-pipe results bundle
//   master : drives flush, ext_stall and the decode descriptor d_*; sees stall, fwd*_sel, q_*
//   slave  : the hazard pipe itself
interface hazard_pipe_if #(
    parameter int AW     = hazard_pkg::D_AW,
    parameter int RW     = hazard_pkg::D_RW,
    parameter int TW     = hazard_pkg::D_TW,
    parameter int NSTAGE = hazard_pkg::D_NSTAGE,
    parameter int SW     = $clog2(NSTAGE + 1)
);
    logic                 flush;
    logic                 ext_stall;
    logic                 d_valid;
    logic [AW-1:0]        d_ra1;
    logic [AW-1:0]        d_ra2;
    logic [AW-1:0]        d_wa;
    logic [RW-1:0]        d_res;
    logic [TW-1:0]        d_tnew;
    logic [TW-1:0]        d_tuse1;
    logic [TW-1:0]        d_tuse2;
    logic                 stall;
    logic [SW-1:0]        fwd1_sel;
    logic [SW-1:0]        fwd2_sel;
    logic [NSTAGE-1:0]    q_valid;
    logic [NSTAGE*AW-1:0] q_ra1;
    logic [NSTAGE*AW-1:0] q_ra2;
    logic [NSTAGE*AW-1:0] q_wa;
    logic [NSTAGE*RW-1:0] q_res;
    logic [NSTAGE*TW-1:0] q_tnew;
    modport master (
        output flush, ext_stall, d_valid, d_ra1, d_ra2, d_wa, d_res, d_tnew, d_tuse1, d_tuse2,
        input  stall, fwd1_sel, fwd2_sel, q_valid, q_ra1, q_ra2, q_wa, q_res, q_tnew
    );
    modport slave (
        input  flush, ext_stall, d_valid, d_ra1, d_ra2, d_wa, d_res, d_tnew, d_tuse1, d_tuse2,
        output stall, fwd1_sel, fwd2_sel, q_valid, q_ra1, q_ra2, q_wa, q_res, q_tnew
    );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: youngest-stage match scan for one decode source operand
//   valid, wa, tnew : flattened stage contents, stage 0 (E) youngest
//   addr            : decode source address
//   hit             : some valid stage writes addr (never for address 0)
//   idx, tnew_m     : youngest matching stage and its current Tnew
module hazard_match #(
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int NSTAGE = 3,
    parameter int SW     = $clog2(NSTAGE + 1)
) (
    input  logic [NSTAGE-1:0]    valid,
    input  logic [NSTAGE*AW-1:0] wa,
    input  logic [NSTAGE*TW-1:0] tnew,
    input  logic [AW-1:0]        addr,
    output logic                 hit,
    output logic [SW-1:0]        idx,
    output logic [TW-1:0]        tnew_m
);
    // scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        tnew_m = '0;
        for (int s = NSTAGE - 1; s >= 0; s--)
            if (valid[s] && wa[s*AW +: AW] != '0 && wa[s*AW +: AW] == addr) begin
                hit    = 1'b1;
                idx    = SW'(s);
                tnew_m = tnew[s*TW +: TW];
            end
    end
endmodule

// File: rtl/hazard_pipe.sv
// hazard_pipe: E..W hazard-descriptor pipeline producing decode stall and forwarding selects
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of hazard_pipe_if (decode descriptor in, stall/fwd/q_* out)
module hazard_pipe
    import hazard_pkg::*;
#(
    parameter int AW     = D_AW,
    parameter int RW     = D_RW,
    parameter int TW     = D_TW,
    parameter int NSTAGE = D_NSTAGE,
    parameter int SW     = $clog2(NSTAGE + 1)
) (
    input logic          clk,
    input logic          rst,
    hazard_pipe_if.slave bus
);
    logic [NSTAGE-1:0]        v;
    logic [NSTAGE*AW-1:0]     r1, r2, w;
    logic [NSTAGE*RW-1:0]     rs;
    logic [NSTAGE*TW-1:0]     tn;
    logic [(NSTAGE-1)*TW-1:0] tn_adv;
    logic                     h1, h2, stall;
    logic [SW-1:0]            i1, i2;
    logic [TW-1:0]            t1, t2;
    logic [AW-1:0]            ld_ra1, ld_ra2, ld_wa;
    logic [RW-1:0]            ld_res;
    logic [TW-1:0]            ld_tnew;

    hazard_match #(.AW(AW), .TW(TW), .NSTAGE(NSTAGE), .SW(SW)) u_m1 (
        .valid(v), .wa(w), .tnew(tn), .addr(bus.d_ra1), .hit(h1), .idx(i1), .tnew_m(t1)
    );
    hazard_match #(.AW(AW), .TW(TW), .NSTAGE(NSTAGE), .SW(SW)) u_m2 (
        .valid(v), .wa(w), .tnew(tn), .addr(bus.d_ra2), .hit(h2), .idx(i2), .tnew_m(t2)
    );

    // only stages that move on need a decremented Tnew; the last stage retires
    for (genvar g = 0; g < NSTAGE - 1; g++) begin : g_adv
        assign tn_adv[g*TW +: TW] = TW'(TNEW_SAT_ZERO(32'(tn[g*TW +: TW])));
    end

    assign stall = bus.ext_stall |
                   (bus.d_valid & ((h1 & (t1 > bus.d_tuse1)) | (h2 & (t2 > bus.d_tuse2))));

    // a stalled decode becomes an all-zero bubble in E
    assign ld_ra1  = stall ? '0 : bus.d_ra1;
    assign ld_ra2  = stall ? '0 : bus.d_ra2;
    assign ld_wa   = stall ? '0 : bus.d_wa;
    assign ld_res  = stall ? '0 : bus.d_res;
    assign ld_tnew = stall ? '0 : bus.d_tnew;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            v  <= '0;
            r1 <= '0;
            r2 <= '0;
            w  <= '0;
            rs <= '0;
            tn <= '0;
        end else begin
            v  <= {v[NSTAGE-2:0], bus.d_valid & ~stall};
            r1 <= {r1[(NSTAGE-1)*AW-1:0], ld_ra1};
            r2 <= {r2[(NSTAGE-1)*AW-1:0], ld_ra2};
            w  <= {w[(NSTAGE-1)*AW-1:0], ld_wa};
            rs <= {rs[(NSTAGE-1)*RW-1:0], ld_res};
            tn <= {tn_adv, ld_tnew};
        end
    end

    assign bus.stall    = stall;
    assign bus.fwd1_sel = (h1 && t1 == '0) ? i1 + SW'(1) : '0;
    assign bus.fwd2_sel = (h2 && t2 == '0) ? i2 + SW'(1) : '0;
    assign bus.q_valid  = v;
    assign bus.q_ra1    = r1;
    assign bus.q_ra2    = r2;
    assign bus.q_wa     = w;
    assign bus.q_res    = rs;
    assign bus.q_tnew   = tn;
endmodule

// File: doc/hazard_pipe.md
Name: hazard_pipe

Overview:
- Parametrised hazard-descriptor pipeline for the exception-capable MIPS core.
- Carries each instruction's read addresses, write address, result type and Tnew countdown from E through W, over NSTAGE stages.
- Computes the decode stall and the per-operand forwarding selects from its own contents.
- Supports bubble insertion, global flush on exception/eret, and Tnew decrement on every advance.
- Replaces the separate fixed-width per-stage hazard registers.

Parameters:
- AW, 5: register address width.
- RW, 3: result-type code width.
- TW, 2: Tnew/Tuse width.
- NSTAGE, 3: pipeline depth. Stage 0 = E, stage 1 = M, stage 2 = W.
- SW, $clog2(NSTAGE+1): forwarding-select width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception/eret clear of all stages
- ext_stall  in  1  external decode stall (e.g. mult/div busy)
- d_valid  in  1  decode holds a real instruction
- d_ra1  in  AW  decode source 1 address
- d_ra2  in  AW  decode source 2 address
- d_wa  in  AW  decode destination address
- d_res  in  RW  decode result type
- d_tnew  in  TW  cycles until result ready, counted from E entry
- d_tuse1  in  TW  cycles until source 1 needed
- d_tuse2  in  TW  cycles until source 2 needed
- stall  out  1  freeze PC/IF-ID and insert bubble into E
- fwd1_sel  out  SW  0 = register file, k = forward from stage k-1
- fwd2_sel  out  SW  same encoding, for source 2
- q_valid  out  NSTAGE  per-stage valid
- q_ra1  out  NSTAGE*AW  flattened per stage; stage s at bits [s*AW +: AW]
- q_ra2  out  NSTAGE*AW  flattened, same packing
- q_wa  out  NSTAGE*AW  flattened, same packing
- q_res  out  NSTAGE*RW  flattened, packed on RW
- q_tnew  out  NSTAGE*TW  flattened, packed on TW

Behaviour:
- Reset: rst high at a clk edge clears every stage field to 0. After reset all q_* = 0; stall, fwd1_sel, fwd2_sel = 0.
- Advance: every non-reset, non-flush edge, stage s+1 <= stage s. Stages downstream of E never freeze. The last stage's contents retire.
- Stage 0 load:
  - If stall = 0: stage 0 <= decode descriptor, with valid = d_valid.
  - If stall = 1: stage 0 <= bubble (all fields 0).
- Tnew on advance: next tnew = (tnew == 0) ? 0 : tnew - 1, saturating, never wraps. Stage 0 load takes d_tnew unmodified.
- Flush: all stages cleared at the edge, same as reset. Priority is rst > flush > advance. A stall in the same cycle is ignored because the decode instruction is discarded upstream.
- Match: stage s matches source address A iff valid[s], wa[s] != 0, and wa[s] == A. Address 0 never matches.
- Youngest match: the lowest s that matches. Older stages are shadowed by it.
- Forward select: fwdN_sel = s+1 iff the youngest match for d_raN is stage s and tnew[s] == 0. Otherwise fwdN_sel = 0.
- Stall, combinational from current contents:
  - stall = ext_stall OR (d_valid AND any source N whose youngest match s has tnew[s] > d_tuseN).
  - Equal Tnew and Tuse does not stall.
- Latency: descriptor visible on stage 0 outputs one cycle after decode. Stage k is visible k+1 cycles after decode.
- Stall and fwd outputs have zero latency (combinational) and no dependency on flush in the same cycle.
- No combinational path from stall back into d_*.

Decomposition:
- Shared package hazard_pkg:
  - result-type codes: RES_NONE, RES_ALU, RES_DM, RES_PC, RES_MD, RES_CP0;
  - typedef of the descriptor struct {valid, ra1, ra2, wa, res, tnew};
  - TNEW_SAT_ZERO helper function.
- Natural sub-module: hazard_match, one instance per source. It performs the youngest-match priority scan and outputs the matched stage index, a hit flag and the matched tnew.

Test Plan:
- Reset: hold rst 2 cycles with garbage d_* -> all q_* = 0, stall = 0, fwd*_sel = 0.
- Load-use: lw $8 (d_tnew=2) then add using $8 with tuse1=0 -> stall = 1 for 2 cycles, bubbles in E. Then fwd1_sel = 3 (W) and stall = 0.
- ALU forward: addu $5 (tnew=1) then subu with ra2=$5, tuse2=1 -> no stall. Next cycle the instruction is in M with tnew=0, so fwd2_sel = 2.
- Shadowing: $9 written by stages 1 (tnew 0) and 0 (tnew 1), decode tuse1=0 reads $9 -> stall = 1, fwd1_sel = 0 (youngest is stage 0).
- Zero register: d_wa=0, then read $0 with tuse 0 -> never stalls, fwd = 0.
- Flush mid-stall: load-use stall active, assert flush one cycle -> next cycle all q_valid = 0, stall = 0, tnew all 0. Reissue proceeds normally.
